// File: rtl/mvp_matrix_seq_if.sv
// Handshake bundle for mvp_matrix_seq: the matrix/mode request channel and the result channel.
interface mvp_matrix_seq_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_mode;
  logic [15:0][DATA_W-1:0]  model_in;
  logic [15:0][DATA_W-1:0]  view_in;
  logic [15:0][DATA_W-1:0]  proj_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [15:0][DATA_W-1:0]  mvp_out;

  modport master (
    output in_valid, in_mode, model_in, view_in, proj_in, out_ready,
    input  in_ready, out_valid, mvp_out
  );

  modport slave (
    input  in_valid, in_mode, model_in, view_in, proj_in, out_ready,
    output in_ready, out_valid, mvp_out
  );
endinterface

// File: rtl/mvp_matrix_seq.sv
// Sequential MVP = P*(V*M) (or V*M in mode 1) using one 4-term dot product per cycle.
// Define MVP_SAT_EN to clamp every reduced element instead of wrapping to DATA_W bits.
module mvp_matrix_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input logic             Clk,
  input logic             Reset_n,
  mvp_matrix_seq_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 2;
`ifdef MVP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef logic [15:0][DATA_W-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_e;

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  mat_t                     t_q, t_d;
  mat_t                     mvp_q, mvp_d;
  mat_t                     m_q, v_q, p_q;
  logic                     mode_q;
  logic                     capture;

  mat_t                     a_mat, b_mat;
  logic signed [DATA_W-1:0] a_row [4];
  logic signed [DATA_W-1:0] b_col [4];
  logic signed [PW-1:0]     prod  [4];
  logic signed [SW-1:0]     acc, shifted;
  logic [DATA_W-1:0]        dot;

  // Row idx/4 of the left operand against column idx%4 of the right operand.
  always_comb begin
    a_mat = (state_q == PASS2) ? p_q : v_q;
    b_mat = (state_q == PASS2) ? t_q : m_q;
    acc   = '0;
    for (int k = 0; k < 4; k++) begin
      a_row[k] = a_mat[{idx_q[3:2], 2'(k)}];
      b_col[k] = b_mat[{2'(k), idx_q[1:0]}];
      prod[k]  = PW'(a_row[k]) * PW'(b_col[k]);
      acc      = acc + SW'(prod[k]);
    end
    shifted = acc >>> FRAC_W;
    if (SAT_EN && shifted > SAT_MAX)      dot = SAT_MAX[DATA_W-1:0];
    else if (SAT_EN && shifted < SAT_MIN) dot = SAT_MIN[DATA_W-1:0];
    else                                  dot = shifted[DATA_W-1:0];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    t_d     = t_q;
    mvp_d   = mvp_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = PASS1;
        end
      end
      PASS1: begin
        t_d[idx_q] = dot;
        idx_d      = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          if (mode_q) begin
            // NOTE: blocking assignments in combinational logic are ordered, so this copy already holds element 15.
            mvp_d   = t_d;
            state_d = DONE;
          end else begin
            state_d = PASS2;
          end
        end
      end
      PASS2: begin
        mvp_d[idx_q] = dot;
        idx_d        = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      t_q     <= '0;
      mvp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      mvp_q   <= mvp_d;
    end
  end

  // NOTE: operand registers are only read after a capture, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (capture) begin
      m_q    <= bus.model_in;
      v_q    <= bus.view_in;
      p_q    <= bus.proj_in;
      mode_q <= bus.in_mode;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.mvp_out   = mvp_q;
endmodule
